// File: rtl/imem_fetch_if.sv
// Bundle of loader, memory, decode and redirect signals around the fetch sequencer.
// The master side is the sequencer; the slave side is everything it talks to.
interface imem_fetch_if #(
  parameter int N = 24
);
  logic         ld_valid;
  logic [7:0]   ld_addr;
  logic [N-1:0] ld_data;
  logic         ld_ready;
  logic         ld_start;
  logic         mem_we;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic [N-1:0] instr;
  logic [N-1:0] instr_pc;
  logic         instr_valid;
  logic         instr_ready;
  logic         redirect;
  logic [N-1:0] redirect_pc;
  logic         busy;
  logic         halted;

  modport master (
    input  ld_valid, ld_addr, ld_data, ld_start, mem_rdata,
           instr_ready, redirect, redirect_pc,
    output ld_ready, mem_we, mem_addr, mem_wdata, instr, instr_pc,
           instr_valid, busy, halted
  );

  modport slave (
    output ld_valid, ld_addr, ld_data, ld_start, mem_rdata,
           instr_ready, redirect, redirect_pc,
    input  ld_ready, mem_we, mem_addr, mem_wdata, instr, instr_pc,
           instr_valid, busy, halted
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction memory sequencer: owns the write port while a program is loaded,
// then fetches one word at a time and presents it to decode with valid/ready.
// mem_addr is a register, so it already supplies the first cycle of the read
// latency; the attached memory contributes the remaining LAT-1 cycles.
module imem_fetch_ctrl #(
  parameter int             N       = 24,
  parameter int             DEPTH   = 256,
  parameter int             LAT     = 1,
  parameter logic [N-1:0]   HALT_OP = 24'hFFFFFF
) (
  input  logic         clk,
  input  logic         rst,
  imem_fetch_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    PRESENT,
    HALTED
  } state_t;

  localparam logic [2:0] LAT_C = 3'(LAT);

  state_t       state;
  logic [N-1:0] pc;
  logic [2:0]   cnt;

  // Fold an arbitrary jump target into the memory address range.
  function automatic logic [N-1:0] wrap_pc(input logic [N-1:0] a);
    wrap_pc = N'(32'(a) % 32'(DEPTH));
  endfunction

  // Sequential successor of a PC, wrapping from the last word back to 0.
  function automatic logic [N-1:0] next_pc(input logic [N-1:0] a);
    next_pc = (a == N'(DEPTH - 1)) ? '0 : a + N'(1);
  endfunction

  // Single state machine; every output is a register updated with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      pc              <= '0;
      cnt             <= '0;
      bus.mem_we      <= 1'b0;
      bus.mem_addr    <= '0;
      bus.mem_wdata   <= '0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
      bus.busy        <= 1'b0;
      bus.halted      <= 1'b0;
      bus.ld_ready    <= 1'b1;
    end else begin
      bus.mem_we <= 1'b0;
      if (state != IDLE && bus.redirect) begin
        pc              <= wrap_pc(bus.redirect_pc);
        cnt             <= '0;
        bus.instr_valid <= 1'b0;
        bus.busy        <= 1'b1;
        bus.halted      <= 1'b0;
        state           <= ISSUE;
      end else begin
        case (state)
          IDLE: begin
            if (bus.ld_valid) begin
              bus.mem_we    <= 1'b1;
              bus.mem_addr  <= N'(bus.ld_addr);
              bus.mem_wdata <= bus.ld_data;
            end
            if (bus.ld_start) begin
              pc           <= '0;
              bus.busy     <= 1'b1;
              bus.ld_ready <= 1'b0;
              state        <= ISSUE;
            end
          end
          ISSUE: begin
            bus.mem_addr <= pc;
            cnt          <= 3'd1;
            state        <= WAIT;
          end
          WAIT: begin
            if (cnt == LAT_C) begin
              bus.instr       <= bus.mem_rdata;
              bus.instr_pc    <= pc;
              bus.instr_valid <= 1'b1;
              state           <= PRESENT;
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
          PRESENT: begin
            if (bus.instr_ready) begin
              bus.instr_valid <= 1'b0;
              if (bus.instr == HALT_OP) begin
                bus.busy   <= 1'b0;
                bus.halted <= 1'b1;
                state      <= HALTED;
              end else begin
                pc    <= next_pc(pc);
                state <= ISSUE;
              end
            end
          end
          HALTED: begin
            bus.instr_valid <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl with LAT=2 and a 256-word memory behind it.
module tb_imem_fetch_ctrl;

  localparam int          N       = 24;
  localparam int          DEPTH   = 256;
  localparam int          LAT     = 2;
  localparam logic [23:0] HALT_OP = 24'hFFFFFF;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  logic [23:0] ref_mem [0:255];
  logic [23:0] tb_mem  [0:255];
  logic [23:0] rpipe   [0:3];

  int          cycles;
  int          model_pc;
  bit          model_halted;
  bit          model_valid;
  int          since;
  bit          do_redir;
  bit          do_ready;
  logic [31:0] tmp;
  logic [23:0] tgt;
  logic [23:0] new_word;
  logic [23:0] hold_instr;

  imem_fetch_if #(.N(N)) bus ();

  imem_fetch_ctrl #(
    .N(N),
    .DEPTH(DEPTH),
    .LAT(LAT),
    .HALT_OP(HALT_OP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Memory model: write port plus LAT-1 read register stages behind mem_addr.
  always @(posedge clk) begin
    if (bus.mem_we) tb_mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    rpipe[0] <= tb_mem[bus.mem_addr[7:0]];
    for (int k = 1; k < 4; k++) rpipe[k] <= rpipe[k-1];
  end

  generate
    if (LAT == 1) begin : g_comb_read
      assign bus.mem_rdata = tb_mem[bus.mem_addr[7:0]];
    end else begin : g_piped_read
      assign bus.mem_rdata = rpipe[LAT-2];
    end
  endgenerate

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value with the bench's own expectation.
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive the full set of inputs for the coming edge.
  task automatic apply_stimulus(input logic lv, input logic [7:0] la, input logic [23:0] ld,
                                input logic ls, input logic rdy, input logic rd,
                                input logic [23:0] rpc);
    bus.ld_valid    = lv;
    bus.ld_addr     = la;
    bus.ld_data     = ld;
    bus.ld_start    = ls;
    bus.instr_ready = rdy;
    bus.redirect    = rd;
    bus.redirect_pc = rpc;
  endtask

  // Wait, bounded, for instr_valid and check the fetch latency from ISSUE.
  task automatic wait_valid(input string tag);
    cycles = 0;
    while (bus.instr_valid !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    check_output({tag, "_latency"}, cycles, LAT + 1);
  endtask

  // Check the presented word against the reference memory at a given PC.
  task automatic check_present(input string tag, input int pc);
    check_output({tag, "_valid"}, bus.instr_valid, 1'b1);
    check_output({tag, "_pc"}, bus.instr_pc, pc);
    check_output({tag, "_instr"}, bus.instr, ref_mem[pc]);
  endtask

  // One-cycle handshake on the presented instruction.
  task automatic accept();
    apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b1, 1'b0, 24'd0);
    tick();
    apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0);
  endtask

  // One-cycle redirect pulse, optionally with instr_ready in the same cycle.
  task automatic jump(input logic [23:0] target, input logic rdy);
    apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, rdy, 1'b1, target);
    tick();
    apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0);
  endtask

  // Directed sequence followed by a randomized run against the transaction model.
  initial begin
    $display("[TB] start, LAT=%0d", LAT);
    for (int i = 0; i < 256; i++) begin
      tmp = $urandom;
      ref_mem[i] = {1'b0, tmp[22:0]};
    end
    ref_mem[0] = 24'h000011;
    ref_mem[1] = 24'h000022;
    ref_mem[2] = HALT_OP;

    // Reset state
    apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_output("rst_ld_ready", bus.ld_ready, 1'b1);
    check_output("rst_busy", bus.busy, 1'b0);
    check_output("rst_halted", bus.halted, 1'b0);
    check_output("rst_valid", bus.instr_valid, 1'b0);
    check_output("rst_mem_we", bus.mem_we, 1'b0);
    check_output("rst_mem_addr", bus.mem_addr, 24'd0);
    check_output("rst_mem_wdata", bus.mem_wdata, 24'd0);
    check_output("rst_instr", bus.instr, 24'd0);
    check_output("rst_instr_pc", bus.instr_pc, 24'd0);

    // Back-to-back load of the whole memory
    for (int i = 0; i < 256; i++) begin
      apply_stimulus(1'b1, 8'(i), ref_mem[i], 1'b0, 1'b0, 1'b0, 24'd0);
      tick();
      check_output("load_we", bus.mem_we, 1'b1);
      check_output("load_addr", bus.mem_addr, i);
      check_output("load_wdata", bus.mem_wdata, ref_mem[i]);
    end
    apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0);
    tick();
    check_output("load_we_drop", bus.mem_we, 1'b0);
    check_output("load_ready_idle", bus.ld_ready, 1'b1);

    // Test 1: start and first fetch
    apply_stimulus(1'b0, 8'd0, 24'd0, 1'b1, 1'b0, 1'b0, 24'd0);
    tick();
    apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0);
    check_output("start_busy", bus.busy, 1'b1);
    check_output("start_ld_ready", bus.ld_ready, 1'b0);
    wait_valid("t1_pc0");
    check_present("t1_pc0", 0);
    accept();
    check_output("t1_valid_drop", bus.instr_valid, 1'b0);

    // Test 2: backpressure on PC 1
    wait_valid("t2_pc1");
    check_present("t2_pc1", 1);
    hold_instr = bus.instr;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("bp_valid", bus.instr_valid, 1'b1);
      check_output("bp_instr", bus.instr, hold_instr);
      check_output("bp_pc", bus.instr_pc, 1);
      check_output("bp_mem_addr", bus.mem_addr, 1);
    end
    accept();
    wait_valid("t2_pc2");
    check_present("t2_pc2", 2);
    accept();
    check_output("halt_halted", bus.halted, 1'b1);
    check_output("halt_busy", bus.busy, 1'b0);
    check_output("halt_valid", bus.instr_valid, 1'b0);
    check_output("halt_mem_addr", bus.mem_addr, 2);
    check_output("halt_ld_ready", bus.ld_ready, 1'b0);
    apply_stimulus(1'b1, 8'd7, 24'h123456, 1'b1, 1'b1, 1'b0, 24'd0);
    tick();
    apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("halt_hold_halted", bus.halted, 1'b1);
      check_output("halt_hold_we", bus.mem_we, 1'b0);
      check_output("halt_hold_valid", bus.instr_valid, 1'b0);
      check_output("halt_hold_addr", bus.mem_addr, 2);
    end

    // Test 4b: resume from HALTED
    jump(24'd0, 1'b0);
    check_output("resume_halted", bus.halted, 1'b0);
    check_output("resume_busy", bus.busy, 1'b1);
    wait_valid("resume_pc0");
    check_present("resume_pc0", 0);
    accept();

    // Test 3: redirect during WAIT for PC 1
    tick();
    check_output("t3_wait_valid", bus.instr_valid, 1'b0);
    jump(24'd200, 1'b0);
    wait_valid("t3_pc200");
    check_present("t3_pc200", 200);

    // Test 4a: redirect beats the handshake of a halt word
    jump(24'd2, 1'b0);
    wait_valid("t4_pc2");
    check_present("t4_pc2", 2);
    jump(24'd5, 1'b1);
    check_output("t4_no_halt", bus.halted, 1'b0);
    check_output("t4_busy", bus.busy, 1'b1);
    check_output("t4_valid_drop", bus.instr_valid, 1'b0);
    wait_valid("t4_pc5");
    check_present("t4_pc5", 5);

    // Test 5: wrap from the last word
    jump(24'd255, 1'b0);
    wait_valid("t5_pc255");
    check_present("t5_pc255", 255);
    accept();
    wait_valid("t5_wrap");
    check_present("t5_wrap", 0);

    // Randomized run against a transaction-level model
    model_pc = 0;
    model_halted = 1'b0;
    since = LAT + 1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      model_valid = !model_halted && since >= LAT + 1;
      check_output("rand_valid", bus.instr_valid, model_valid);
      check_output("rand_halted", bus.halted, model_halted);
      check_output("rand_busy", bus.busy, !model_halted);
      check_output("rand_we", bus.mem_we, 1'b0);
      if (model_valid) begin
        check_output("rand_pc", bus.instr_pc, model_pc);
        check_output("rand_instr", bus.instr, ref_mem[model_pc]);
      end
      do_redir = ($urandom_range(0, 9) == 0);
      do_ready = ($urandom_range(0, 1) == 1);
      tmp = $urandom;
      if ($urandom_range(0, 3) == 0) tgt = {tmp[23:8], 6'd0, tmp[1:0]};
      else tgt = tmp[23:0];
      apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, do_ready, do_redir, tgt);
      tick();
      if (do_redir) begin
        model_pc = int'(tgt) % DEPTH;
        model_halted = 1'b0;
        since = 0;
      end else if (model_valid && do_ready) begin
        if (ref_mem[model_pc] == HALT_OP) model_halted = 1'b1;
        else model_pc = (model_pc + 1) % DEPTH;
        since = 0;
      end else if (since < 50) begin
        since++;
      end
    end
    apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0);

    // Test 6: reset in the middle of WAIT
    jump(24'd10, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_output("t6_valid", bus.instr_valid, 1'b0);
    check_output("t6_we", bus.mem_we, 1'b0);
    check_output("t6_ld_ready", bus.ld_ready, 1'b1);
    check_output("t6_busy", bus.busy, 1'b0);
    check_output("t6_halted", bus.halted, 1'b0);
    check_output("t6_mem_addr", bus.mem_addr, 24'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check_output("t6_no_stale", bus.instr_valid, 1'b0);
    end

    // Load and start in the same IDLE cycle
    tmp = $urandom;
    new_word = {1'b0, tmp[22:0]};
    if (new_word == ref_mem[0]) new_word = new_word ^ 24'h000100;
    ref_mem[0] = new_word;
    apply_stimulus(1'b1, 8'd0, new_word, 1'b1, 1'b0, 1'b0, 24'd0);
    tick();
    apply_stimulus(1'b0, 8'd0, 24'd0, 1'b0, 1'b0, 1'b0, 24'd0);
    check_output("t6_ls_we", bus.mem_we, 1'b1);
    check_output("t6_ls_addr", bus.mem_addr, 24'd0);
    check_output("t6_ls_wdata", bus.mem_wdata, new_word);
    check_output("t6_ls_busy", bus.busy, 1'b1);
    wait_valid("t6_ls_pc0");
    check_present("t6_ls_pc0", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
